// File: rtl/vga_vert_if.sv
// vga_vert_if
// Groups the signals between the horizontal counter / renderer side and the
// vertical timing stage.
//   hcnt        : 11-bit horizontal count from the horizontal counter
//   hsync_in    : horizontal sync from the horizontal counter, active low
//   hsync       : hsync_in delayed one cycle, aligned with the other outputs
//   vsync       : vertical sync, active low
//   active      : high during visible pixels
//   x, y        : pixel column / row, zero outside the visible area
//   frame_start : one-cycle pulse at line 0, hcnt 0
//   frame_cnt   : completed-frame counter, wraps 255 -> 0
// The master modport is the upstream/downstream side; the slave modport is
// the vertical controller itself.
interface vga_vert_if;
  logic [10:0] hcnt;
  logic        hsync_in;
  logic        hsync;
  logic        vsync;
  logic        active;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        frame_start;
  logic [7:0]  frame_cnt;

  modport master (
    output hcnt, hsync_in,
    input  hsync, vsync, active, x, y, frame_start, frame_cnt
  );

  modport slave (
    input  hcnt, hsync_in,
    output hsync, vsync, active, x, y, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_vert_ctrl.sv
// vga_vert_ctrl
// Vertical timing and pixel-coordinate stage sitting directly after the
// horizontal counter. Keeps the line counter, decodes vertical sync and the
// visible window, produces pixel coordinates, a frame-start pulse and a
// completed-frame counter. Every output is a registered decode of the current
// hcnt and the current (pre-update) line count, so all of them appear exactly
// one cycle after the inputs and stay mutually aligned.
// Ports:
//   clk : pixel clock, shared with the horizontal counter
//   rst : synchronous reset, active high, overrides everything
//   vif : vga_vert_if slave modport (hcnt/hsync_in in, timing outputs out)
module vga_vert_ctrl #(
  parameter int H_LAST       = 1089,
  parameter int H_ACT_START  = 256,
  parameter int H_ACT_END    = 1055,
  parameter int V_LAST       = 524,
  parameter int V_ACT_END    = 479,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 491
) (
  input logic       clk,
  input logic       rst,
  vga_vert_if.slave vif
);

  // Width-matched copies of the timing constants.
  localparam logic [10:0] HLast     = 11'(H_LAST);
  localparam logic [10:0] HActStart = 11'(H_ACT_START);
  localparam logic [10:0] HActEnd   = 11'(H_ACT_END);
  localparam logic [9:0]  VLast     = 10'(V_LAST);
  localparam logic [9:0]  VActEnd   = 10'(V_ACT_END);
  localparam logic [9:0]  VSyncBeg  = 10'(V_SYNC_START);
  localparam logic [9:0]  VSyncEnd  = 10'(V_SYNC_END);

  logic [9:0] vcnt_q,        vcnt_d;
  logic       hsync_q,       hsync_d;
  logic       vsync_q,       vsync_d;
  logic       active_q,      active_d;
  logic [9:0] x_q,           x_d;
  logic [8:0] y_q,           y_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_cnt_q,   frame_cnt_d;

  logic line_end;
  logic frame_end;
  logic hact;
  logic vact;

  // Next-state decode. Everything is derived from hcnt and the line count as
  // it stands this cycle; the new line count only becomes visible in the
  // decode one edge later. An out-of-range hcnt (upstream counter not yet
  // reset) is neither a line end nor inside the visible window, because both
  // checks are exact comparisons below H_LAST.
  always_comb begin
    line_end      = (vif.hcnt == HLast);
    frame_end     = line_end && (vcnt_q >= VLast);
    hact          = (vif.hcnt >= HActStart) && (vif.hcnt <= HActEnd);
    vact          = (vcnt_q <= VActEnd);

    vcnt_d        = vcnt_q;
    frame_cnt_d   = frame_cnt_q;
    if (line_end) begin
      // Values at or past the last line fold back to 0 so a corrupt count
      // recovers within one line.
      vcnt_d = frame_end ? 10'd0 : vcnt_q + 10'd1;
    end
    if (frame_end) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    active_d      = hact && vact;
    x_d           = active_d ? 10'(vif.hcnt - HActStart) : 10'd0;
    y_d           = active_d ? vcnt_q[8:0] : 9'd0;
    vsync_d       = !((vcnt_q >= VSyncBeg) && (vcnt_q <= VSyncEnd));
    hsync_d       = vif.hsync_in;
    frame_start_d = (vcnt_q == 10'd0) && (vif.hcnt == 11'd0);
  end

  // State and output registers; reset parks the syncs inactive (high).
  always_ff @(posedge clk) begin
    if (rst) begin
      vcnt_q        <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 9'd0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      vcnt_q        <= vcnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.active      = active_q;
  assign vif.x           = x_q;
  assign vif.y           = y_q;
  assign vif.frame_start = frame_start_q;
  assign vif.frame_cnt   = frame_cnt_q;

endmodule
